hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, legal range 2..255: the maximum number of freeze cycles allowed for one memory access.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port id_valid, input, 1 bit: the ID-stage instruction is real, not a bubble.
REQ-005 SHALL have ports id_src1 and id_src2, input, 4 bits each: the ID-stage source register numbers.
REQ-006 SHALL have port id_two_src, input, 1 bit: id_src2 is actually read.
REQ-007 SHALL have ports id_dst, input, 4 bits, and id_wb_en, id_mem_r_en, id_mem_w_en, input, 1 bit each: the ID-stage destination and control bits.
REQ-008 SHALL have port mem_ready, input, 1 bit: the memory access in the MEM stage completes this cycle.
REQ-009 SHALL have output ports hazard (1 bit: stall IF/ID and insert a bubble) and freeze (1 bit: hold the whole pipeline).
REQ-010 SHALL have output ports dst_mem and dst_wb (4 bits each) and wb_en_mem and wb_en_wb (1 bit each): the MEM and WB destination tracking fed to the forwarding unit.
REQ-011 SHALL have output port mem_timeout, 1 bit: a sticky memory-timeout error flag.

Function
REQ-012 SHALL hold three stage registers, EXE, MEM and WB, each holding {dst[3:0], wb_en, mem_r_en, mem_w_en}.
REQ-013 SHALL, on each edge with freeze=0, load EXE with the ID fields when id_valid=1 and hazard=0, and otherwise load EXE with a bubble (all control bits 0, dst 0); MEM<=EXE; WB<=MEM.
REQ-014 SHALL, on each edge with freeze=1, hold all three stage registers unchanged.
REQ-015 SHALL drive dst_mem/wb_en_mem directly from the MEM register and dst_wb/wb_en_wb directly from the WB register, with no added latency.
REQ-016 SHALL compute hazard combinationally and force it to 0 when id_valid=0; a src2 comparison counts only when id_two_src=1.
REQ-017 SHALL implement the memory FSM with states IDLE and WAIT and an 8-bit counter cnt.
REQ-018 SHALL, in IDLE: set freeze = (MEM.mem_r_en|MEM.mem_w_en) & ~mem_ready; if freeze=1, go to WAIT with cnt<=1; otherwise stay in IDLE with cnt=0. A single-cycle access therefore causes no freeze.
REQ-019 SHALL, in WAIT: set freeze = ~mem_ready & (cnt<MEM_TIMEOUT); while freeze=1, cnt<=cnt+1.
REQ-020 SHALL, in WAIT with mem_ready=1: freeze=0, the pipeline advances on that edge, go to IDLE, cnt<=0.
REQ-021 SHALL, in WAIT with cnt==MEM_TIMEOUT and mem_ready=0: freeze=0, set mem_timeout<=1, advance the pipeline (the access is abandoned), go to IDLE, cnt<=0.
REQ-022 SHALL freeze for exactly MEM_TIMEOUT cycles in total per access before abandoning it.
REQ-023 SHALL keep mem_timeout at 1 until reset, and SHALL not suppress freeze for later accesses.
REQ-024 SHALL compute hazard independently of freeze, and a hazard held across a freeze SHALL not insert more than one bubble per advancing edge.

Reset
REQ-025 SHALL, when rst=0 at a rising edge, clear all stage registers to bubble (dst 0, control bits 0), set FSM=IDLE, cnt=0 and mem_timeout=0.
REQ-026 SHALL give reset priority over freeze and over any in-progress WAIT.
REQ-027 SHALL, after reset: hazard=0 (with id_valid=0), freeze=0, dst_mem=dst_wb=0, wb_en_mem=wb_en_wb=0.

Configuration
REQ-028 SHALL use the macro HAZ_FORWARD_EN.
REQ-029 SHALL, with HAZ_FORWARD_EN defined, assert hazard only on load-use: EXE.mem_r_en=1 and an active source equals EXE.dst.
REQ-030 SHALL, without HAZ_FORWARD_EN, assert hazard when an active source equals EXE.dst with EXE.wb_en=1, or equals MEM.dst with MEM.wb_en=1; WB matches never stall because the register file writes on the falling edge.
REQ-031 SHALL, without HAZ_FORWARD_EN, force wb_en_mem and wb_en_wb to 0 so that the forwarding unit selects the register file.

Verification
REQ-032 SHALL cover: a load of r3, then the next ID has id_src1=3 (HAZ_FORWARD_EN) -> hazard=1 for 1 cycle, one bubble in EXE, then wb_en_mem=1, dst_mem=3.
REQ-033 SHALL cover: an ADD writing r5, then the next ID has src2=5 with id_two_src=1 -> with HAZ_FORWARD_EN hazard=0; without it hazard=1 for 2 cycles.
REQ-034 SHALL cover: a load reaches MEM with mem_ready low for 3 cycles -> freeze=1 for exactly 3 cycles, stages held, advance on the 4th edge, mem_timeout=0.
REQ-035 SHALL cover: MEM_TIMEOUT=4 with mem_ready held 0 -> freeze=1 for 4 cycles, then 0, mem_timeout=1 and stays 1.
REQ-036 SHALL cover: rst=0 asserted during WAIT (cnt=2) -> the next cycle has freeze=0, state IDLE, all outputs 0.
REQ-037 SHALL cover: id_valid=0 with id_src1 matching EXE.dst of a load -> hazard=0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//
// Purpose: tracks the destination/control fields of the EXE, MEM and WB
// pipeline stages, raises a combinational data hazard (stall IF/ID, insert
// a bubble) and runs a small memory-wait FSM that freezes the whole pipeline
// while a MEM-stage access is outstanding, giving up after MEM_TIMEOUT
// freeze cycles and latching a sticky timeout flag.
//
// Build option: define HAZ_FORWARD_EN when a forwarding unit is present.
//   defined   : only load-use (EXE load feeding an ID source) stalls;
//               wb_en_mem / wb_en_wb reflect the stage registers.
//   undefined : any ID source matching a writing EXE or MEM stage stalls;
//               wb_en_mem / wb_en_wb are tied low so the register file is
//               always selected.
//
// Ports:
//   clk                  clock, all state on rising edge
//   rst                  synchronous reset, active low
//   id_valid             ID instruction is real (not a bubble)
//   id_src1, id_src2     ID source registers; id_two_src qualifies id_src2
//   id_dst, id_wb_en,
//   id_mem_r_en,
//   id_mem_w_en          ID destination and control bits
//   mem_ready            MEM-stage access completes this cycle
//   hazard               stall IF/ID and bubble EXE
//   freeze               hold the entire pipeline
//   dst_mem, wb_en_mem   MEM stage tracking for forwarding
//   dst_wb,  wb_en_wb    WB stage tracking for forwarding
//   mem_timeout          sticky: a memory access was abandoned
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [3:0] id_src1,
    input  logic [3:0] id_src2,
    input  logic       id_two_src,
    input  logic [3:0] id_dst,
    input  logic       id_wb_en,
    input  logic       id_mem_r_en,
    input  logic       id_mem_w_en,
    input  logic       mem_ready,
    output logic       hazard,
    output logic       freeze,
    output logic [3:0] dst_mem,
    output logic [3:0] dst_wb,
    output logic       wb_en_mem,
    output logic       wb_en_wb,
    output logic       mem_timeout
);

    typedef struct packed {
        logic [3:0] dst;
        logic       wb_en;
        logic       mem_r_en;
        logic       mem_w_en;
    } stage_t;

    localparam stage_t BUBBLE = '{dst: 4'd0, wb_en: 1'b0, mem_r_en: 1'b0, mem_w_en: 1'b0};
    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    stage_t     exe_q, exe_d;
    stage_t     mem_q, mem_d;
    stage_t     wb_q,  wb_d;
    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       timeout_q, timeout_d;

    logic       hazard_c;
    logic       freeze_c;
    logic       mem_access;

    // Source-match terms; src2 only participates when it is really read.
    logic       exe_match;
    logic       mem_match;

    assign exe_match = (id_src1 == exe_q.dst) | (id_two_src & (id_src2 == exe_q.dst));
    assign mem_match = (id_src1 == mem_q.dst) | (id_two_src & (id_src2 == mem_q.dst));

    // Hazard is purely a function of ID and the stage registers, never of
    // freeze. Because the stage registers hold while frozen, a hazard that
    // persists through a freeze still yields only one bubble per advance.
    always_comb begin
        hazard_c = 1'b0;
`ifdef HAZ_FORWARD_EN
        hazard_c = id_valid & exe_q.mem_r_en & exe_match;
`else
        // WB matches are safe: the register file writes on the falling edge.
        hazard_c = id_valid & ((exe_q.wb_en & exe_match) | (mem_q.wb_en & mem_match));
`endif
    end

    // Memory wait FSM.
    assign mem_access = mem_q.mem_r_en | mem_q.mem_w_en;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        freeze_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A ready-on-first-cycle access never freezes.
                freeze_c = mem_access & ~mem_ready;
                if (freeze_c) begin
                    state_d = ST_WAIT;
                    cnt_d   = 8'd1;
                end else begin
                    cnt_d = 8'd0;
                end
            end
            ST_WAIT: begin
                if (mem_ready) begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end else if (cnt_q < TIMEOUT_CNT) begin
                    freeze_c = 1'b1;
                    cnt_d    = cnt_q + 8'd1;
                end else begin
                    // The IDLE cycle plus MEM_TIMEOUT-1 WAIT cycles have been
                    // spent frozen: abandon the access and let the pipe move.
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                    cnt_d     = 8'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Stage register next values.
    always_comb begin
        exe_d = exe_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (!freeze_c) begin
            if (id_valid && !hazard_c) begin
                exe_d.dst      = id_dst;
                exe_d.wb_en    = id_wb_en;
                exe_d.mem_r_en = id_mem_r_en;
                exe_d.mem_w_en = id_mem_w_en;
            end else begin
                exe_d = BUBBLE;
            end
            mem_d = exe_q;
            wb_d  = mem_q;
        end
    end

    // Reset wins over freeze and over any pending wait.
    always_ff @(posedge clk) begin
        if (!rst) begin
            exe_q     <= BUBBLE;
            mem_q     <= BUBBLE;
            wb_q      <= BUBBLE;
            state_q   <= ST_IDLE;
            cnt_q     <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            exe_q     <= exe_d;
            mem_q     <= mem_d;
            wb_q      <= wb_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign hazard      = hazard_c;
    assign freeze      = freeze_c;
    assign dst_mem     = mem_q.dst;
    assign dst_wb      = wb_q.dst;
    assign mem_timeout = timeout_q;

`ifdef HAZ_FORWARD_EN
    assign wb_en_mem = mem_q.wb_en;
    assign wb_en_wb  = wb_q.wb_en;
`else
    assign wb_en_mem = 1'b0;
    assign wb_en_wb  = 1'b0;
`endif

    // WB memory-control bits (and WB write enable without forwarding) are
    // carried for completeness but have no consumer here.
    logic unused_wb_bits;
    assign unused_wb_bits = ^{wb_q.wb_en, wb_q.mem_r_en, wb_q.mem_w_en};

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Directed bench for hazard_scoreboard (MEM_TIMEOUT = 4). Inputs change on
// the falling edge, outputs are sampled 1 ns later. Expected values are hand
// computed; those that depend on HAZ_FORWARD_EN select between both answers.
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard;

`ifdef HAZ_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [3:0] id_src1;
    logic [3:0] id_src2;
    logic       id_two_src;
    logic [3:0] id_dst;
    logic       id_wb_en;
    logic       id_mem_r_en;
    logic       id_mem_w_en;
    logic       mem_ready;
    logic       hazard;
    logic       freeze;
    logic [3:0] dst_mem;
    logic [3:0] dst_wb;
    logic       wb_en_mem;
    logic       wb_en_wb;
    logic       mem_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_scoreboard #(.MEM_TIMEOUT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_src1     (id_src1),
        .id_src2     (id_src2),
        .id_two_src  (id_two_src),
        .id_dst      (id_dst),
        .id_wb_en    (id_wb_en),
        .id_mem_r_en (id_mem_r_en),
        .id_mem_w_en (id_mem_w_en),
        .mem_ready   (mem_ready),
        .hazard      (hazard),
        .freeze      (freeze),
        .dst_mem     (dst_mem),
        .dst_wb      (dst_wb),
        .wb_en_mem   (wb_en_mem),
        .wb_en_wb    (wb_en_wb),
        .mem_timeout (mem_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic drive_id(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                            input logic two, input logic [3:0] d, input logic wb,
                            input logic mr, input logic mw);
        id_valid    = v;
        id_src1     = s1;
        id_src2     = s2;
        id_two_src  = two;
        id_dst      = d;
        id_wb_en    = wb;
        id_mem_r_en = mr;
        id_mem_w_en = mw;
    endtask

    task automatic idle_id();
        drive_id(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drain();
        repeat (4) begin
            cyc();
            idle_id();
        end
    endtask

    initial begin
        rst       = 1'b0;
        mem_ready = 1'b1;
        idle_id();
        cyc();
        cyc();
        settle();
        check_val("rst_hazard",    32'(hazard),      32'd0);
        check_val("rst_freeze",    32'(freeze),      32'd0);
        check_val("rst_dst_mem",   32'(dst_mem),     32'd0);
        check_val("rst_dst_wb",    32'(dst_wb),      32'd0);
        check_val("rst_wb_en_mem", 32'(wb_en_mem),   32'd0);
        check_val("rst_wb_en_wb",  32'(wb_en_wb),    32'd0);
        check_val("rst_timeout",   32'(mem_timeout), 32'd0);
        rst = 1'b1;

        // ADD r5, then a consumer reading r5 through src2.
        cyc(); drive_id(1, 4'd1, 4'd2, 1, 4'd5, 1, 0, 0); settle();
        check_val("add_no_haz", 32'(hazard), 32'd0);
        cyc(); drive_id(1, 4'd7, 4'd5, 0, 4'd6, 1, 0, 0); settle();
        check_val("src2_inactive", 32'(hazard), 32'd0);
        id_two_src = 1'b1; settle();
        check_val("raw_exe", 32'(hazard), FWD ? 32'd0 : 32'd1);
        cyc(); settle();
        check_val("raw_mem", 32'(hazard), FWD ? 32'd0 : 32'd1);
        check_val("raw_dst_mem", 32'(dst_mem), 32'd5);
        cyc(); settle();
        check_val("raw_wb_nostall", 32'(hazard), 32'd0);
        check_val("raw_dst_wb", 32'(dst_wb), 32'd5);
        check_val("raw_dst_mem2", 32'(dst_mem), FWD ? 32'd6 : 32'd0);
        check_val("raw_wb_en_wb", 32'(wb_en_wb), FWD ? 32'd1 : 32'd0);
        drain();

        // Load r3 followed by a use of r3 through src1.
        cyc(); drive_id(1, 4'd1, 4'd0, 0, 4'd3, 1, 1, 0); settle();
        check_val("ld_issue", 32'(hazard), 32'd0);
        cyc(); drive_id(0, 4'd3, 4'd0, 0, 4'd4, 1, 0, 0); settle();
        check_val("lu_invalid", 32'(hazard), 32'd0);
        id_valid = 1'b1; settle();
        check_val("lu_exe", 32'(hazard), 32'd1);
        cyc(); settle();
        check_val("lu_after", 32'(hazard), FWD ? 32'd0 : 32'd1);
        check_val("lu_freeze", 32'(freeze), 32'd0);
        check_val("lu_dst_mem", 32'(dst_mem), 32'd3);
        check_val("lu_wb_en_mem", 32'(wb_en_mem), FWD ? 32'd1 : 32'd0);
        cyc(); id_valid = 1'b0; settle();
        check_val("lu_bubble", 32'(dst_mem), 32'd0);
        check_val("lu_dst_wb", 32'(dst_wb), 32'd3);
        check_val("lu_wb_en_wb", 32'(wb_en_wb), FWD ? 32'd1 : 32'd0);
        drain();

        // Load r9 waits 3 cycles for memory; younger ADD r8 must be held.
        cyc(); drive_id(1, 4'd1, 4'd0, 0, 4'd9, 1, 1, 0); settle();
        cyc(); idle_id(); settle();
        check_val("w_pre_freeze", 32'(freeze), 32'd0);
        cyc(); mem_ready = 1'b0; drive_id(1, 4'd1, 4'd2, 0, 4'd8, 1, 0, 0); settle();
        check_val("w_freeze1", 32'(freeze), 32'd1);
        check_val("w_hazard", 32'(hazard), 32'd0);
        cyc(); settle();
        check_val("w_freeze2", 32'(freeze), 32'd1);
        cyc(); settle();
        check_val("w_freeze3", 32'(freeze), 32'd1);
        check_val("w_hold_mem", 32'(dst_mem), 32'd9);
        cyc(); mem_ready = 1'b1; settle();
        check_val("w_release", 32'(freeze), 32'd0);
        check_val("w_still_mem", 32'(dst_mem), 32'd9);
        cyc(); idle_id(); settle();
        check_val("w_adv_wb", 32'(dst_wb), 32'd9);
        check_val("w_exe_held", 32'(dst_mem), 32'd0);
        check_val("w_no_timeout", 32'(mem_timeout), 32'd0);
        cyc(); settle();
        check_val("w_issue_after", 32'(dst_mem), 32'd8);
        drain();

        // Load r10 never completes: 4 freeze cycles then abandon.
        cyc(); drive_id(1, 4'd1, 4'd0, 0, 4'd10, 1, 1, 0); settle();
        cyc(); idle_id(); settle();
        cyc(); mem_ready = 1'b0; settle();
        check_val("to_freeze1", 32'(freeze), 32'd1);
        for (int i = 2; i <= 4; i++) begin
            cyc(); settle();
            check_val("to_freezeN", 32'(freeze), 32'd1);
        end
        cyc(); settle();
        check_val("to_release", 32'(freeze), 32'd0);
        check_val("to_flag_pre", 32'(mem_timeout), 32'd0);
        check_val("to_dst_mem", 32'(dst_mem), 32'd10);
        cyc(); settle();
        check_val("to_flag", 32'(mem_timeout), 32'd1);
        check_val("to_dst_wb", 32'(dst_wb), 32'd10);
        check_val("to_freeze_off", 32'(freeze), 32'd0);
        cyc(); settle();
        check_val("to_sticky", 32'(mem_timeout), 32'd1);

        // Load r11 stalls again after the timeout; reset during WAIT (cnt=2).
        cyc(); mem_ready = 1'b1; drive_id(1, 4'd1, 4'd0, 0, 4'd11, 1, 1, 0); settle();
        cyc(); idle_id(); settle();
        cyc(); mem_ready = 1'b0; settle();
        check_val("r_freeze1", 32'(freeze), 32'd1);
        check_val("r_dst_mem", 32'(dst_mem), 32'd11);
        cyc(); settle();
        check_val("r_freeze2", 32'(freeze), 32'd1);
        cyc(); rst = 1'b0; settle();
        check_val("r_pre_rst", 32'(freeze), 32'd1);
        cyc(); rst = 1'b1; settle();
        check_val("r_freeze", 32'(freeze), 32'd0);
        check_val("r_timeout", 32'(mem_timeout), 32'd0);
        check_val("r_dst_mem0", 32'(dst_mem), 32'd0);
        check_val("r_dst_wb0", 32'(dst_wb), 32'd0);
        check_val("r_hazard", 32'(hazard), 32'd0);
        check_val("r_wb_en_mem", 32'(wb_en_mem), 32'd0);
        check_val("r_wb_en_wb", 32'(wb_en_wb), 32'd0);
        cyc(); settle();
        check_val("r_idle", 32'(freeze), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
